// File: rtl/frame_deserializer.sv
// frame_deserializer
//   Collects MSB-first serial words from a PISO stage into a shadow bank and
//   publishes a complete, in-order frame (word 0..N_WORDS-1) to a readout bank.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   serial_in    serial data bit, MSB first
//   SL           load strobe: 1 = word load cycle, 0 = shift cycles
//   sel          word index captured on a load cycle
//   ovf_in       overflow indication, accumulated over a frame
//   rd_addr      readout bank address (values >= N_WORDS read as 0)
//   rd_data      readout bank word, combinational read
//   word_valid   1-cycle pulse: a word was written to the shadow bank
//   word_idx     index of the word flagged by word_valid
//   frame_valid  1-cycle pulse: readout bank updated with a full frame
//   frame_err    1-cycle pulse: short word, bad index or out-of-order word
//   frame_ovf    overflow flag of the last published frame
module frame_deserializer #(
  parameter int unsigned WORD_W  = 12,
  parameter int unsigned N_WORDS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              SL,
  input  logic [2:0]        sel,
  input  logic              ovf_in,
  input  logic [2:0]        rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              word_valid,
  output logic [2:0]        word_idx,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              frame_ovf
);

  localparam int unsigned      CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [2:0]       LAST_IDX = 3'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  // Holds the first WORD_W-1 bits; the last bit is taken straight from
  // serial_in on the completing cycle so the word is available one cycle early.
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [2:0]        cur_idx_q, cur_idx_d;
  logic [2:0]        exp_idx_q, exp_idx_d;
  logic [WORD_W-1:0] shadow_q [N_WORDS];
  logic [WORD_W-1:0] shadow_d [N_WORDS];
  logic [WORD_W-1:0] bank_q   [N_WORDS];
  logic [WORD_W-1:0] bank_d   [N_WORDS];
  logic              ovf_q, ovf_d;
  logic              word_valid_q, word_valid_d;
  logic [2:0]        word_idx_q, word_idx_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              frame_ovf_q, frame_ovf_d;
  logic [WORD_W-1:0] word_full;

  assign word_full = {shift_q, serial_in};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    cur_idx_d     = cur_idx_q;
    exp_idx_d     = exp_idx_q;
    shadow_d      = shadow_q;
    bank_d        = bank_q;
    ovf_d         = ovf_q | ovf_in;
    word_valid_d  = 1'b0;
    word_idx_d    = word_idx_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    frame_ovf_d   = frame_ovf_q;

    if (SL) begin
      // A load while still shifting means the previous word was short.
      if (state_q == SHIFT) begin
        frame_err_d = 1'b1;
        exp_idx_d   = '0;
        ovf_d       = 1'b0;
      end
      // Loading word 0 opens a new frame for overflow accumulation.
      if (sel == '0) begin
        ovf_d = ovf_in;
      end
      state_d   = SHIFT;
      cur_idx_d = sel;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (state_q == SHIFT) begin
      shift_d   = {shift_q[WORD_W-3:0], serial_in};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == LAST_BIT) begin
        state_d = WAIT;
        // Index 0 is always accepted: it restarts the frame.
        if (cur_idx_q > LAST_IDX ||
            (cur_idx_q != exp_idx_q && cur_idx_q != '0)) begin
          frame_err_d = 1'b1;
          exp_idx_d   = '0;
          ovf_d       = 1'b0;
        end else begin
          shadow_d[cur_idx_q] = word_full;
          word_valid_d        = 1'b1;
          word_idx_d          = cur_idx_q;
          if (cur_idx_q == LAST_IDX) begin
            bank_d        = shadow_d;
            frame_valid_d = 1'b1;
            frame_ovf_d   = ovf_q | ovf_in;
            ovf_d         = 1'b0;
            exp_idx_d     = '0;
          end else begin
            exp_idx_d = cur_idx_q + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      cur_idx_q     <= '0;
      exp_idx_q     <= '0;
      ovf_q         <= 1'b0;
      word_valid_q  <= 1'b0;
      word_idx_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < N_WORDS; i++) begin
        shadow_q[i] <= '0;
        bank_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      cur_idx_q     <= cur_idx_d;
      exp_idx_q     <= exp_idx_d;
      ovf_q         <= ovf_d;
      word_valid_q  <= word_valid_d;
      word_idx_q    <= word_idx_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_ovf_q   <= frame_ovf_d;
      shadow_q      <= shadow_d;
      bank_q        <= bank_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr <= LAST_IDX) begin
      rd_data = bank_q[rd_addr];
    end
  end

  assign word_valid  = word_valid_q;
  assign word_idx    = word_idx_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_ovf   = frame_ovf_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// tb_frame_deserializer
//   Directed stimulus for frame_deserializer with a transaction-level model
//   (word/frame rules) checked every cycle, plus literal spot checks.
module tb_frame_deserializer;

  logic        clk;
  logic        reset;
  logic        serial_in;
  logic        SL;
  logic [2:0]  sel;
  logic        ovf_in;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic        word_valid;
  logic [2:0]  word_idx;
  logic        frame_valid;
  logic        frame_err;
  logic        frame_ovf;

  frame_deserializer #(
    .WORD_W (12),
    .N_WORDS(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .SL         (SL),
    .sel        (sel),
    .ovf_in     (ovf_in),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .word_valid (word_valid),
    .word_idx   (word_idx),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .frame_ovf  (frame_ovf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wv_seen = 0;
  int rd_sweep = 0;

  // Model state
  logic [11:0] m_shadow [5];
  logic [11:0] m_bank   [5];
  int          m_exp;
  bit          m_ovf;
  bit          m_fovf;
  bit          short_pending;
  bit          e_wv, e_fv, e_fe;
  int          e_wi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] exp_rd;
    exp_rd = (rd_addr < 3'd5) ? m_bank[rd_addr] : 12'h000;
    chk("word_valid", 32'(word_valid), 32'(e_wv));
    chk("frame_valid", 32'(frame_valid), 32'(e_fv));
    chk("frame_err", 32'(frame_err), 32'(e_fe));
    chk("frame_ovf", 32'(frame_ovf), 32'(m_fovf));
    chk("rd_data", 32'(rd_data), 32'(exp_rd));
    if (e_wv) chk("word_idx", 32'(word_idx), 32'(e_wi));
    if (word_valid) wv_seen++;
  end

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      m_shadow[k] = '0;
      m_bank[k]   = '0;
    end
    m_exp = 0; m_ovf = 0; m_fovf = 0; short_pending = 0;
    e_wv = 0; e_fv = 0; e_fe = 0; e_wi = 0;
  endtask

  task automatic tick();
    m_ovf = m_ovf | ovf_in;
    @(posedge clk);
    #1;
    e_wv = 0; e_fv = 0; e_fe = 0;
    rd_sweep++;
    rd_addr = rd_sweep[2:0];
  endtask

  task automatic complete(input int s, input logic [11:0] w);
    if (s > 4) begin
      e_fe = 1; m_exp = 0; m_ovf = 0;
    end else if (s == m_exp || s == 0) begin
      m_shadow[s] = w; e_wv = 1; e_wi = s;
      if (s == 4) begin
        for (int k = 0; k < 5; k++) m_bank[k] = m_shadow[k];
        e_fv = 1; m_fovf = m_ovf; m_ovf = 0; m_exp = 0;
      end else begin
        m_exp = s + 1;
      end
    end else begin
      e_fe = 1; m_exp = 0; m_ovf = 0;
    end
  endtask

  // Load cycle followed by nbits shift cycles; ovf_bit selects a bit cycle
  // (0-based) carrying ovf_in=1, -1 for none.
  task automatic send_word(input int s, input logic [11:0] w, input int nbits, input int ovf_bit);
    SL = 1'b1; sel = 3'(s); serial_in = 1'b0; ovf_in = 1'b0;
    if (short_pending || s == 0) m_ovf = 0;
    tick();
    if (short_pending) begin
      e_fe = 1; m_exp = 0; short_pending = 0;
    end
    SL = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      serial_in = w[11-i];
      ovf_in    = (i == ovf_bit);
      tick();
    end
    ovf_in = 1'b0;
    if (nbits == 12) complete(s, w);
    else short_pending = 1;
  endtask

  task automatic idle(input int n);
    SL = 1'b0; ovf_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      serial_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic frame(input logic [59:0] ws, input int ovf_word, input int gap);
    for (int k = 0; k < 5; k++) begin
      send_word(k, ws[59-12*k -: 12], 12, (k == ovf_word) ? 6 : -1);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b0;
    model_clear();
    SL = 1'b0; ovf_in = 1'b0;
    tick();
    tick();
    m_ovf = 0;
    reset = 1'b1;
  endtask

  task automatic lit_rd(input int a, input logic [11:0] v, input string nm);
    rd_addr = 3'(a);
    #1;
    chk(nm, 32'(rd_data), 32'(v));
  endtask

  initial begin
    logic [59:0] rw;
    int base;
    reset = 1'b0; SL = 1'b0; sel = '0; serial_in = 1'b0; ovf_in = 1'b0; rd_addr = '0;
    model_clear();
    repeat (3) tick();
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_frame_ovf", 32'(frame_ovf), 32'd0);
    lit_rd(0, 12'h000, "rst_rd0");
    lit_rd(4, 12'h000, "rst_rd4");
    reset = 1'b1;

    // Serial activity without a load strobe must not produce anything
    idle(14);

    // Full frame
    base = wv_seen;
    frame({12'h001, 12'h0A5, 12'h800, 12'hFFF, 12'h3C7}, -1, 0);
    chk("f1_frame_valid", 32'(frame_valid), 32'd1);
    chk("f1_frame_ovf", 32'(frame_ovf), 32'd0);
    lit_rd(0, 12'h001, "f1_rd0");
    lit_rd(1, 12'h0A5, "f1_rd1");
    lit_rd(2, 12'h800, "f1_rd2");
    lit_rd(3, 12'hFFF, "f1_rd3");
    lit_rd(4, 12'h3C7, "f1_rd4");
    lit_rd(5, 12'h000, "f1_rd5");
    idle(2);
    chk("f1_wv_count", 32'(wv_seen - base), 32'd5);

    // Short word (5 bits), then a full word 0x123 and the rest of the frame
    send_word(0, 12'h0AA, 5, -1);
    send_word(0, 12'h123, 12, -1);
    chk("short_then_wv", 32'(word_valid), 32'd1);
    chk("short_then_noerr", 32'(frame_err), 32'd0);
    send_word(1, 12'h456, 12, -1);
    send_word(2, 12'h789, 12, -1);
    send_word(3, 12'hABC, 12, -1);
    send_word(4, 12'hDEF, 12, -1);
    idle(1);

    // 11-bit short word right at the boundary, then out-of-order 0,1,3
    send_word(0, 12'h555, 11, -1);
    send_word(0, 12'h111, 12, -1);
    send_word(1, 12'h222, 12, -1);
    send_word(3, 12'h333, 12, -1);
    chk("ooo_err", 32'(frame_err), 32'd1);
    chk("ooo_no_wv", 32'(word_valid), 32'd0);
    idle(2);
    lit_rd(0, 12'h123, "ooo_rd0_kept");
    lit_rd(3, 12'hABC, "ooo_rd3_kept");
    frame({12'h010, 12'h020, 12'h030, 12'h040, 12'h050}, -1, 2);

    // Overflow during word 2, then a clean frame
    frame({12'hA01, 12'hA02, 12'hA03, 12'hA04, 12'hA05}, 2, 0);
    chk("ovf_frame_ovf", 32'(frame_ovf), 32'd1);
    idle(3);
    frame({12'hB01, 12'hB02, 12'hB03, 12'hB04, 12'hB05}, -1, 1);
    chk("clean_frame_ovf", 32'(frame_ovf), 32'd0);

    // Invalid indices; word 1 after an error is out of order
    send_word(6, 12'hC06, 12, -1);
    chk("sel6_err", 32'(frame_err), 32'd1);
    chk("sel6_no_wv", 32'(word_valid), 32'd0);
    send_word(1, 12'hC01, 12, -1);
    chk("after_sel6_err", 32'(frame_err), 32'd1);
    send_word(5, 12'hC05, 12, -1);
    idle(1);

    // Word 0 mid-frame restarts the frame without error
    send_word(0, 12'hD00, 12, -1);
    send_word(1, 12'hD01, 12, -1);
    send_word(0, 12'hE00, 12, -1);
    chk("restart_noerr", 32'(frame_err), 32'd0);
    send_word(1, 12'hE01, 12, -1);
    send_word(2, 12'hE02, 12, -1);
    send_word(3, 12'hE03, 12, 3);
    send_word(4, 12'hE04, 12, -1);
    chk("restart_fv", 32'(frame_valid), 32'd1);
    lit_rd(0, 12'hE00, "restart_rd0");
    idle(2);

    // Reset mid-frame after word 2, partway through word 3
    send_word(0, 12'hF00, 12, -1);
    send_word(1, 12'hF01, 12, -1);
    send_word(2, 12'hF02, 12, -1);
    send_word(3, 12'hF03, 6, -1);
    do_reset();
    lit_rd(0, 12'h000, "rst_mid_rd0");
    lit_rd(4, 12'h000, "rst_mid_rd4");
    chk("rst_mid_ovf", 32'(frame_ovf), 32'd0);
    idle(13);
    rw[31:0]  = $urandom;
    rw[59:32] = 28'($urandom);
    frame(rw, -1, 0);
    chk("post_rst_fv", 32'(frame_valid), 32'd1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_deserializer.md
FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

Interface
REQ-001 Parameters: WORD_W, default 12, bits per serial word; N_WORDS, default 5, words per frame (ch1..ch4, RTC).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 serial_in  input  1  serial data from the PISO stage, MSB first.
REQ-005 SL  input  1  load strobe; high = word load cycle, low = shift cycles.
REQ-006 sel  input  3  word index {a2,a1,a0} for the word being loaded; sampled when SL=1.
REQ-007 ovf_in  input  1  overflow indication (ch or RTC), sampled every cycle.
REQ-008 rd_addr  input  3  readout bank word address, 0..4.
REQ-009 rd_data  output  WORD_W  readout bank word at rd_addr, combinational read.
REQ-010 word_valid  output  1  one-cycle pulse; a complete word was just written to the shadow bank.
REQ-011 word_idx  output  3  index of the word flagged by word_valid.
REQ-012 frame_valid  output  1  one-cycle pulse; readout bank updated with a complete frame.
REQ-013 frame_err  output  1  one-cycle pulse on any protocol error.
REQ-014 frame_ovf  output  1  sticky-per-frame overflow flag; valid with, and held after, frame_valid.

Function
REQ-015 FSM states: IDLE, SHIFT, WAIT.
REQ-016 SL=1 in any state: capture sel into cur_idx, clear bit counter and shift register, go to SHIFT.
REQ-017 SHIFT, SL=0: shift register <= {shift[WORD_W-2:0], serial_in}, bit counter +1.
REQ-018 When the bit counter reaches WORD_W (12th shift cycle sampled), go to WAIT; next cycle word_valid=1, word_idx=cur_idx.
REQ-019 WAIT, SL=0: serial_in ignored, no state change.
REQ-020 SL=1 in SHIFT before WORD_W bits (short word): partial word discarded, frame_err pulses one cycle later, new word load proceeds per REQ-016.
REQ-021 Word acceptance: accepted only if cur_idx equals expected index (0 after reset or frame end/error); accepted word written to shadow[cur_idx], expected index +1.
REQ-022 Completed word with cur_idx /= expected: not written, frame_err pulses with the would-be word_valid cycle, expected index resets to 0; if cur_idx=0 the word is accepted as start of a new frame instead (no error).
REQ-023 sel > N_WORDS-1 on load: word shifted but discarded, frame_err pulses at completion, expected index resets to 0.
REQ-024 Completion of word N_WORDS-1 accepted: same cycle as word_valid, all shadow words copied to readout bank, frame_valid=1, expected index resets to 0.
REQ-025 frame_ovf: internal sticky accumulates ovf_in from start of frame (word 0 load) to frame completion; copied to frame_ovf at frame_valid; internal sticky cleared on frame_valid or frame_err.
REQ-026 Readout bank changes only at frame_valid; rd_data stable between frames; rd_addr > 4 returns 0.
REQ-027 word_valid and frame_err never both high for the same word unless REQ-022 error; frame_valid never with frame_err.
REQ-028 Latency: SL load cycle at T, bits sampled T+1..T+12, word_valid at T+13, frame_valid (last word) at T+13.

Reset
REQ-029 reset=0 asynchronously: FSM IDLE, bit counter 0, expected index 0, shift register, shadow and readout banks 0, word_valid/frame_valid/frame_err/frame_ovf 0, internal ovf sticky 0.
REQ-030 Reset mid-word or mid-frame discards all partial data; no pulses generated on release.
REQ-031 First valid word after reset release requires a fresh SL=1 cycle.

Verification
REQ-032 Full frame: sel 0..4, words 0x001,0x0A5,0x800,0xFFF,0x3C7 (13-cycle slots) -> five word_valid pulses, frame_valid with 5th, rd_data[0..4] match, frame_ovf=0.
REQ-033 Short word: load sel=0, 5 bits, SL=1 sel=0 -> frame_err one pulse, then full word 0x123 accepted with word_valid, no further error.
REQ-034 Out of order: words sel=0,1,3 -> frame_err at sel=3 completion; readout bank unchanged; following frame 0..4 yields frame_valid.
REQ-035 Overflow: ovf_in=1 for one cycle during word 2 -> frame_ovf=1 at frame_valid; next clean frame -> frame_ovf=0.
REQ-036 Invalid index: sel=6 word -> frame_err, no word_valid, expected index 0.
REQ-037 Reset mid-frame after word 2 -> all outputs 0, rd_data 0; subsequent full frame completes normally.
